// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, opcode and immediate-issue buffer types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
  typedef struct packed {
    word_t instr;
    word_t imm;
    logic  used;
  } imm_entry_t;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: opcode to sign-extender controls and immediate-usage flag
module imm_decode
  import cpu_types_pkg::*;
#(
  parameter bit ZEXT_LOGIC = 1'b1
) (
  input  logic [5:0] opcode,
  output logic       lui,
  output logic       sext,
  output logic       used
);
  // unknown opcodes fall through as non-immediate instructions
  always_comb begin
    lui  = 1'b0;
    sext = 1'b0;
    used = 1'b1;
    case (opcode)
      OP_LUI: lui = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI: sext = !ZEXT_LOGIC;
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: sext = 1'b1;
      default: used = 1'b0;
    endcase
  end
endmodule

// File: rtl/imm_issue_ctrl.sv
// imm_issue_ctrl: ID-stage extender control with a 2-entry skid buffer toward EX
module imm_issue_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter bit ZEXT_LOGIC = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_instr,
  output logic [WORD_W-1:0] se_Instruction,
  output logic              se_LUI,
  output logic              se_SignExtend,
  input  logic [WORD_W-1:0] se_InstrE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_imm,
  output logic              out_imm_used,
  output logic [CNT_W-1:0]  imm_count
);
  skid_state_t state;
  imm_entry_t  e0, e1, nw;
  logic        used, push, pop;
  imm_decode #(.ZEXT_LOGIC(ZEXT_LOGIC)) u_dec (
    .opcode(in_instr[31:26]),
    .lui   (se_LUI),
    .sext  (se_SignExtend),
    .used  (used)
  );
  assign se_Instruction = in_instr;
  // ready depends only on registered state so EX backpressure never reaches IF combinationally
  assign in_ready     = !RST && state != TWO;
  assign out_valid    = !RST && state != EMPTY;
  assign out_instr    = RST ? '0 : e0.instr;
  assign out_imm      = RST ? '0 : e0.imm;
  assign out_imm_used = !RST && e0.used;
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign nw           = '{instr: in_instr, imm: used ? se_InstrE : '0, used: used};
  // skid buffer: entry0 is the head, entry1 only holds data while EX stalls
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= EMPTY;
      e0        <= '0;
      e1        <= '0;
      imm_count <= '0;
    end else begin
      if (push && !flush && used && imm_count != '1) imm_count <= imm_count + 1'b1;
      if (flush) state <= EMPTY;
      else if (state == EMPTY) begin
        if (push) begin
          e0    <= nw;
          state <= ONE;
        end
      end else if (state == ONE) begin
        if (push && pop) e0 <= nw;
        else if (push) begin
          e1    <= nw;
          state <= TWO;
        end else if (pop) state <= EMPTY;
      end else if (pop) begin
        e0    <= e1;
        state <= ONE;
      end
    end
  end
endmodule

// File: tb/tb_imm_issue_ctrl.sv
// tb_imm_issue_ctrl: directed vectors and corner sequences for imm_issue_ctrl
module tb_imm_issue_ctrl;
  logic        CLK = 0, RST = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, se_InstrE, se_Instruction, out_instr, out_imm;
  logic        in_ready, se_LUI, se_SignExtend, out_valid, out_imm_used;
  logic [3:0]  imm_count;
  int          errs = 0, checks = 0, ecnt = 0;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        used, lui, sext;
  } vec_t;
  vec_t v[12];
  localparam logic [31:0] A = 32'h20010001, B = 32'h00221820, C = 32'h34010005;

  imm_issue_ctrl #(.WORD_W(32), .ZEXT_LOGIC(1'b1), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .se_Instruction(se_Instruction), .se_LUI(se_LUI),
    .se_SignExtend(se_SignExtend), .se_InstrE(se_InstrE), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_imm(out_imm),
    .out_imm_used(out_imm_used), .imm_count(imm_count)
  );

  always #5 CLK = ~CLK;

  // behavioural stand-in for the external sign extender
  always_comb
    se_InstrE = se_LUI ? {se_Instruction[15:0], 16'h0} :
                se_SignExtend ? {{16{se_Instruction[15]}}, se_Instruction[15:0]} :
                {16'h0, se_Instruction[15:0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1; flush = 0; in_valid = 0; out_ready = 0;
    tick();
    RST = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{32'h2001FFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
    v[1]  = '{32'h34018000, 32'h00008000, 1'b1, 1'b0, 1'b0};
    v[2]  = '{32'h3C011234, 32'h12340000, 1'b1, 1'b1, 1'b0};
    v[3]  = '{32'h00221820, 32'h00000000, 1'b0, 1'b0, 1'b0};
    v[4]  = '{32'h3021F0F0, 32'h0000F0F0, 1'b1, 1'b0, 1'b0};
    v[5]  = '{32'h38218001, 32'h00008001, 1'b1, 1'b0, 1'b0};
    v[6]  = '{32'h8C21FFFC, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1};
    v[7]  = '{32'hAC210010, 32'h00000010, 1'b1, 1'b0, 1'b1};
    v[8]  = '{32'h1022FFFE, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1};
    v[9]  = '{32'h08000010, 32'h00000000, 1'b0, 1'b0, 1'b0};
    v[10] = '{32'h2C218000, 32'hFFFF8000, 1'b1, 1'b0, 1'b1};
    v[11] = '{32'hFC00FFFF, 32'h00000000, 1'b0, 1'b0, 1'b0};

    // reset state, decode stays live during reset
    in_instr = v[0].instr;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_imm_count", imm_count, 0);
    chk("rst_decode_sext", se_SignExtend, 1);
    RST = 0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    // streaming vector table with EX always ready
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; in_instr = v[i].instr;
      #1;
      chk($sformatf("v%0d_lui", i), se_LUI, v[i].lui);
      chk($sformatf("v%0d_sext", i), se_SignExtend, v[i].sext);
      chk($sformatf("v%0d_se_instr", i), se_Instruction, v[i].instr);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      if (v[i].used) ecnt++;
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_out_instr", i), out_instr, v[i].instr);
      chk($sformatf("v%0d_out_imm", i), out_imm, v[i].imm);
      chk($sformatf("v%0d_imm_used", i), out_imm_used, v[i].used);
      chk($sformatf("v%0d_imm_count", i), imm_count, ecnt);
    end
    in_valid = 0;
    tick();
    chk("drain_out_valid", out_valid, 0);

    // backpressure: A,B fill the buffer, C waits until A drains
    do_reset();
    in_valid = 1; in_instr = A; tick();
    in_instr = B; tick();
    chk("bp_in_ready_two", in_ready, 0);
    chk("bp_head_a", out_instr, A);
    in_instr = C; tick();
    chk("bp_stall_in_ready", in_ready, 0);
    chk("bp_stall_head", out_instr, A);
    out_ready = 1; tick();
    chk("bp_head_b", out_instr, B);
    chk("bp_in_ready_one", in_ready, 1);
    chk("bp_b_imm_used", out_imm_used, 0);
    tick();
    in_valid = 0;
    chk("bp_head_c", out_instr, C);
    chk("bp_c_imm", out_imm, 32'h00000005);
    chk("bp_count", imm_count, 2);
    tick();
    chk("bp_empty", out_valid, 0);

    // flush from TWO drops the same-cycle push and keeps the count
    do_reset();
    in_valid = 1; in_instr = A; tick();
    in_instr = B; tick();
    chk("fl_count_before", imm_count, 1);
    flush = 1; in_instr = C; tick();
    flush = 0; in_valid = 0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_count", imm_count, 1);

    // reset mid-operation with two entries and count 5
    do_reset();
    out_ready = 1; in_valid = 1; in_instr = A;
    repeat (3) tick();
    in_valid = 0; tick();
    out_ready = 0; in_valid = 1; in_instr = C;
    repeat (2) tick();
    in_valid = 0;
    chk("mr_count5", imm_count, 5);
    chk("mr_full", in_ready, 0);
    RST = 1;
    #1;
    chk("mr_during_out_valid", out_valid, 0);
    chk("mr_during_out_imm", out_imm, 0);
    chk("mr_during_imm_used", out_imm_used, 0);
    tick();
    RST = 0;
    #1;
    chk("mr_count0", imm_count, 0);
    chk("mr_empty", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);

    // saturation of the 4-bit counter
    out_ready = 1; in_valid = 1; in_instr = v[0].instr;
    repeat (15) tick();
    chk("sat_count15", imm_count, 4'hF);
    tick();
    chk("sat_hold", imm_count, 4'hF);
    in_valid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
